// File: rtl/riscv_lsu_pkg.sv
// Shared load/store defines: funct3 size encodings, FSM state type and the
// alignment legality rule used by the LSU.
package riscv_lsu_pkg;

  localparam int ALU_OP_WIDTH = 4;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  // Sizes 3, 6 and 7 have no load/store meaning and are always rejected.
  function automatic logic access_legal(input logic [2:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      LDST_B, LDST_BU: ok = 1'b1;
      LDST_H, LDST_HU: ok = ~addr_lo[0];
      LDST_W:          ok = (addr_lo == 2'b00);
      default:         ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Byte-lane steering: byte enables, store-data replication and load-data
// extraction with sign/zero extension. Purely combinational.
module riscv_lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wd,
  input  logic [31:0] rd_raw,
  output logic [3:0]  be,
  output logic [31:0] wd_rep,
  output logic [31:0] rd_ext
);

  logic [31:0] rd_shift;

  always_comb begin
    rd_shift = rd_raw >> {addr_lo, 3'b000};
    be       = 4'b1111;
    wd_rep   = wd;
    rd_ext   = rd_shift;
    // size[2] marks the unsigned variants, so it suppresses the sign fill
    case (size)
      LDST_B, LDST_BU: begin
        be     = 4'b0001 << addr_lo;
        wd_rep = {4{wd[7:0]}};
        rd_ext = {{24{rd_shift[7] & ~size[2]}}, rd_shift[7:0]};
      end
      LDST_H, LDST_HU: begin
        be     = 4'b0011 << addr_lo;
        wd_rep = {2{wd[15:0]}};
        rd_ext = {{16{rd_shift[15] & ~size[2]}}, rd_shift[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: accepts one core access at a time, runs it on the memory
// bus with a ready timeout, and returns aligned load data.
//
// state | meaning
// IDLE  | waiting for a core request; illegal requests fault here
// WAIT  | bus request held until mem_ready_i or timeout
// DONE  | one-cycle result/fault presentation
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_req_o,
  output logic        lsu_fault_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e       state, state_next;
  logic [31:0]      addr_q, wd_q, rd_q;
  logic             we_q, timeout_q;
  logic [2:0]       size_q;
  logic [CNT_W-1:0] cnt;
  logic             req_legal, wait_last;
  logic [3:0]       be;
  logic [31:0]      wd_rep, rd_ext;

  assign req_legal = access_legal(core_size_i, core_addr_i[1:0]);
  assign wait_last = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (core_req_i && req_legal) state_next = WAIT;
      WAIT:    if (mem_ready_i || wait_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q    <= '0;
      wd_q      <= '0;
      rd_q      <= '0;
      we_q      <= 1'b0;
      size_q    <= '0;
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt       <= '0;
          timeout_q <= 1'b0;
          if (core_req_i && req_legal) begin
            addr_q <= core_addr_i;
            wd_q   <= core_wd_i;
            we_q   <= core_we_i;
            size_q <= core_size_i;
          end
        end
        WAIT: begin
          // ready on the last allowed cycle still completes without a fault
          if (mem_ready_i) begin
            if (!we_q) rd_q <= mem_rd_i;
          end else if (wait_last) begin
            timeout_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  riscv_lsu_align u_align (
    .size    (size_q),
    .addr_lo (addr_q[1:0]),
    .wd      (wd_q),
    .rd_raw  (rd_q),
    .be      (be),
    .wd_rep  (wd_rep),
    .rd_ext  (rd_ext)
  );

  always_comb begin
    mem_req_o        = (state == WAIT);
    mem_we_o         = (state == WAIT) && we_q;
    mem_be_o         = (state == WAIT) ? be : 4'b0000;
    mem_addr_o       = {addr_q[31:2], 2'b00};
    mem_wd_o         = wd_rep;
    core_stall_req_o = core_req_i && (((state == IDLE) && req_legal) || (state == WAIT));
    lsu_fault_o      = ((state == IDLE) && core_req_i && !req_legal) ||
                       ((state == DONE) && timeout_q);
    core_rd_o        = ((state == DONE) && !we_q && !timeout_q) ? rd_ext : 32'h0;
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: directed scenarios plus randomized
// accesses compared against an arithmetic byte-lane model.
module tb_riscv_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        core_req_i, core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i, core_wd_i, core_rd_o;
  logic        core_stall_req_o, lsu_fault_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wd_o, mem_rd_i;
  logic        mem_ready_i;

  int n_checks = 0;
  int n_fail   = 0;

  riscv_lsu #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .core_req_i       (core_req_i),
    .core_we_i        (core_we_i),
    .core_size_i      (core_size_i),
    .core_addr_i      (core_addr_i),
    .core_wd_i        (core_wd_i),
    .core_rd_o        (core_rd_o),
    .core_stall_req_o (core_stall_req_o),
    .lsu_fault_o      (lsu_fault_o),
    .mem_req_o        (mem_req_o),
    .mem_we_o         (mem_we_o),
    .mem_be_o         (mem_be_o),
    .mem_addr_o       (mem_addr_o),
    .mem_wd_o         (mem_wd_o),
    .mem_rd_i         (mem_rd_i),
    .mem_ready_i      (mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] size);
    case (size)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit m_legal(input logic [2:0] size, input logic [31:0] addr);
    int b = nbytes(size);
    return (b != 0) && ((addr % b) == 0);
  endfunction

  function automatic logic [31:0] m_be(input logic [2:0] size, input logic [31:0] addr);
    int b = nbytes(size);
    return 32'(((1 << b) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] size, input logic [31:0] wd);
    int b = nbytes(size);
    if (b == 1) return (wd & 32'hFF) * 32'h0101_0101;
    if (b == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] size, input logic [31:0] addr,
                                         input logic [31:0] rd);
    int b = nbytes(size);
    logic [31:0] v, mask;
    v = rd >> ((addr % 4) * 8);
    if (b == 4) return v;
    mask = 32'((64'd1 << (8 * b)) - 1);
    v = v & mask;
    if (size < 3'd4 && ((v >> (8 * b - 1)) & 32'd1) == 32'd1) v = v | ~mask;
    return v;
  endfunction

  task automatic idle_inputs();
    core_req_i  = 1'b0;
    core_we_i   = 1'b0;
    core_size_i = 3'd0;
    core_addr_i = '0;
    core_wd_i   = '0;
    mem_ready_i = 1'b0;
    mem_rd_i    = '0;
  endtask

  // delay = WAIT cycles before ready; 16 or more means the bus never answers.
  task automatic run_txn(input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input int delay,
                         input bit drop_req);
    bit lg = m_legal(size, addr);
    bit tmo = (delay >= 16);
    @(posedge clk_i); #1;
    core_req_i  = 1'b1;
    core_we_i   = we;
    core_size_i = size;
    core_addr_i = addr;
    core_wd_i   = wd;
    mem_ready_i = 1'b1;
    mem_rd_i    = $urandom;
    #1;
    check("idle_mem_req", 32'(mem_req_o), 32'd0);
    if (!lg) begin
      check("illegal_fault", 32'(lsu_fault_o), 32'd1);
      check("illegal_stall", 32'(core_stall_req_o), 32'd0);
      @(posedge clk_i); #1;
      idle_inputs();
      #1;
      check("illegal_after_fault", 32'(lsu_fault_o), 32'd0);
      check("illegal_after_req", 32'(mem_req_o), 32'd0);
      return;
    end
    check("req_stall", 32'(core_stall_req_o), 32'd1);
    check("req_fault", 32'(lsu_fault_o), 32'd0);
    for (int k = 0; k < 16; k++) begin
      @(posedge clk_i); #1;
      if (drop_req && k > 0) core_req_i = 1'b0;
      core_addr_i = $urandom;
      core_wd_i   = $urandom;
      core_size_i = 3'($urandom);
      mem_ready_i = (k == delay);
      mem_rd_i    = (k == delay) ? rd : $urandom;
      #1;
      check("wait_req", 32'(mem_req_o), 32'd1);
      check("wait_we", 32'(mem_we_o), 32'(we));
      check("wait_be", 32'(mem_be_o), m_be(size, addr));
      check("wait_addr", mem_addr_o, addr & 32'hFFFF_FFFC);
      check("wait_wd", mem_wd_o, m_wd(size, wd));
      check("wait_stall", 32'(core_stall_req_o), 32'(core_req_i));
      check("wait_fault", 32'(lsu_fault_o), 32'd0);
      if (k == delay) break;
    end
    @(posedge clk_i); #1;
    idle_inputs();
    mem_ready_i = 1'b1;
    mem_rd_i    = $urandom;
    #1;
    check("done_req", 32'(mem_req_o), 32'd0);
    check("done_we", 32'(mem_we_o), 32'd0);
    check("done_be", 32'(mem_be_o), 32'd0);
    check("done_stall", 32'(core_stall_req_o), 32'd0);
    check("done_fault", 32'(lsu_fault_o), 32'(tmo));
    check("done_rd", core_rd_o, (we || tmo) ? 32'd0 : m_load(size, addr, rd));
    @(posedge clk_i); #1;
    mem_ready_i = 1'b0;
    #1;
    check("post_done_req", 32'(mem_req_o), 32'd0);
    check("post_done_fault", 32'(lsu_fault_o), 32'd0);
  endtask

  initial begin
    logic [2:0]  sz;
    logic [31:0] a;
    int          d;
    idle_inputs();
    rst_i = 1'b1;
    @(posedge clk_i);
    @(posedge clk_i); #1;
    check("rst_core_rd", core_rd_o, 32'd0);
    check("rst_fault", 32'(lsu_fault_o), 32'd0);
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_mem_be", 32'(mem_be_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_mem_wd", mem_wd_o, 32'd0);
    check("rst_stall", 32'(core_stall_req_o), 32'd0);
    rst_i = 1'b0;

    // LB 0x1003: be 1000, 0x80 sign-extended
    run_txn(1'b0, 3'd0, 32'h0000_1003, 32'h0, 32'h80FF_FFFF, 0, 1'b0);
    // SH 0x2002: replicated halfword on upper lanes
    run_txn(1'b1, 3'd1, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 2, 1'b0);
    // misaligned LW
    run_txn(1'b0, 3'd2, 32'h0000_0006, 32'h0, 32'h0, 0, 1'b0);
    // timeout, then ready on the final allowed WAIT cycle
    run_txn(1'b0, 3'd2, 32'h0000_0010, 32'h0, 32'h0, 20, 1'b0);
    run_txn(1'b0, 3'd2, 32'h0000_0010, 32'h0, 32'h1234_5678, 15, 1'b0);
    // core drops its request mid-transaction
    run_txn(1'b0, 3'd5, 32'h0000_0042, 32'h0, 32'hCAFE_F00D, 3, 1'b1);
    // illegal sizes
    run_txn(1'b0, 3'd3, 32'h0000_0000, 32'h0, 32'h0, 0, 1'b0);
    run_txn(1'b1, 3'd6, 32'h0000_0000, 32'h0, 32'h0, 0, 1'b0);
    run_txn(1'b0, 3'd7, 32'h0000_0004, 32'h0, 32'h0, 0, 1'b0);

    // reset in WAIT cycle 3
    @(posedge clk_i); #1;
    core_req_i  = 1'b1;
    core_size_i = 3'd2;
    core_addr_i = 32'h0000_0010;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_i); #1;
      mem_ready_i = 1'b0;
      #1;
      check("rst_wait_req", 32'(mem_req_o), 32'd1);
    end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    idle_inputs();
    #1;
    check("rst_mid_req", 32'(mem_req_o), 32'd0);
    check("rst_mid_fault", 32'(lsu_fault_o), 32'd0);
    run_txn(1'b0, 3'd4, 32'h0000_1001, 32'h0, 32'h0000_AB00, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    sz = 3'd0;
        2:       sz = 3'd4;
        3, 4:    sz = 3'd1;
        5:       sz = 3'd5;
        6, 7:    sz = 3'd2;
        8:       sz = ($urandom_range(0, 1) == 0) ? 3'd3 : 3'd6;
        default: sz = 3'd7;
      endcase
      a = $urandom;
      if ($urandom_range(0, 3) != 0 && nbytes(sz) != 0)
        a = a & ~32'(nbytes(sz) - 1);
      d = ($urandom_range(0, 9) == 0) ? 16 + $urandom_range(0, 3) : $urandom_range(0, 5);
      run_txn(1'($urandom), sz, a, $urandom, $urandom, d, $urandom_range(0, 7) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, the maximum number of cycles the block waits for mem_ready_i before faulting.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port core_req_i, input, 1 bit: the core requests a memory access (decoder mem_req).
REQ-005 SHALL have port core_we_i, input, 1 bit: 1 = store, 0 = load.
REQ-006 SHALL have port core_size_i, input, 3 bits: access size, RISC-V funct3 encoding (0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU).
REQ-007 SHALL have port core_addr_i, input, 32 bits: byte address.
REQ-008 SHALL have port core_wd_i, input, 32 bits: store data, right-aligned.
REQ-009 SHALL have port core_rd_o, output, 32 bits: load result, aligned and extended.
REQ-010 SHALL have port core_stall_req_o, output, 1 bit: holds the core pipeline.
REQ-011 SHALL have port lsu_fault_o, output, 1 bit: one-cycle pulse on a misaligned access, an illegal size, or a timeout.
REQ-012 SHALL have these memory-side ports: mem_req_o (output, 1), mem_we_o (output, 1), mem_be_o (output, 4), mem_addr_o (output, 32), mem_wd_o (output, 32), mem_rd_i (input, 32), mem_ready_i (input, 1).

Function
REQ-013 SHALL implement the FSM states IDLE, WAIT and DONE.
REQ-014 In IDLE, a legal core_req_i SHALL latch addr, we, size and wd, and the FSM SHALL move to WAIT next cycle.
REQ-015 Legality: H/HU accesses need addr[0]=0; W accesses need addr[1:0]=0; sizes 3, 6 and 7 are illegal.
REQ-016 In IDLE, an illegal request SHALL pulse lsu_fault_o in the same cycle, keep core_stall_req_o=0, perform no bus access, and stay in IDLE.
REQ-017 In WAIT, mem_req_o SHALL be 1 and all mem_* outputs SHALL be held stable until mem_ready_i=1 is sampled; the FSM then moves to DONE.
REQ-018 mem_addr_o SHALL be {addr[31:2], 2'b00}.
REQ-019 mem_be_o SHALL be 4'b0001<<addr[1:0] for B, 4'b0011<<addr[1:0] for H, and 4'b1111 for W.
REQ-020 mem_wd_o SHALL be {4{wd[7:0]}} for B, {2{wd[15:0]}} for H, and wd for W.
REQ-021 On a load, mem_rd_i SHALL be registered when mem_ready_i=1. In DONE, core_rd_o SHALL equal that data shifted right by addr[1:0]*8, then sign-extended (B/H) or zero-extended (BU/HU).
REQ-022 On a store, core_rd_o SHALL be 0 in DONE.
REQ-023 core_stall_req_o SHALL be 1 while core_req_i=1 and the state is IDLE-with-legal-request or WAIT, and 0 in DONE.
REQ-024 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-025 Latency: a request in cycle N with mem_ready_i=1 in cycle N+1 SHALL give DONE and data in N+2; each extra wait cycle adds 1.
REQ-026 A WAIT cycle counter SHALL start at 0. Reaching TIMEOUT_CYCLES without ready SHALL deassert mem_req_o, go to DONE with core_rd_o=0, and pulse lsu_fault_o in DONE.
REQ-027 If mem_ready_i and the timeout occur in the same cycle, ready SHALL win and no fault is raised.
REQ-028 If core_req_i drops during WAIT, the bus transaction SHALL still complete; the result is discarded.
REQ-029 mem_ready_i SHALL be ignored in IDLE and DONE.
REQ-030 Outside WAIT, mem_req_o, mem_we_o and mem_be_o SHALL be 0.

Reset
REQ-031 When rst_i=1 at a clock edge, the FSM SHALL go to IDLE and the counter to 0.
REQ-032 After reset, all registered outputs SHALL be 0, including core_rd_o, lsu_fault_o, mem_req_o, mem_be_o, mem_addr_o and mem_wd_o.
REQ-033 A reset during WAIT SHALL drop mem_req_o in the following cycle, without waiting for mem_ready_i.

Structure
REQ-034 The size encodings (LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU) SHALL be defined in the shared defines file alongside the ALU opcode width.
REQ-035 Byte-enable generation, store-data replication and load extraction SHALL live in one combinational sub-module, riscv_lsu_align.
REQ-036 The FSM and timeout counter SHALL reside in riscv_lsu.

Verification
REQ-037 Byte load: LB at 0x1003 with mem_rd_i=0x80FF_FFFF and ready after 1 cycle -> mem_be_o=4'b1000, core_rd_o=0xFFFF_FF80, stall lasts 2 cycles.
REQ-038 Halfword store: SH at 0x2002 with wd=0x0000_BEEF -> mem_addr_o=0x2000, mem_be_o=4'b1100, mem_wd_o=0xBEEF_BEEF, mem_we_o=1.
REQ-039 Misaligned word: LW at 0x0006 -> lsu_fault_o=1 for one cycle, mem_req_o never asserted, stall=0.
REQ-040 Timeout: LW at 0x10 with mem_ready_i held 0 -> mem_req_o drops after 16 WAIT cycles, then fault pulse and core_rd_o=0 in DONE.
REQ-041 Ready on the timeout cycle: mem_ready_i=1 in WAIT cycle 16 with mem_rd_i=0x1234_5678 -> no fault, core_rd_o=0x1234_5678.
REQ-042 Reset mid-operation: rst_i=1 in WAIT cycle 3 -> mem_req_o=0 on the next cycle, the FSM is in IDLE, and a following LBU at 0x1001 with mem_rd_i=0x0000_AB00 returns 0x0000_00AB.
